pseudo_spi_rx_intf: RTL and testbench
=====================================

# pseudo_spi_rx_intf

Serial-to-SRAM loader: the write-direction counterpart of the pseudo-SPI readout interface. When started, it acts as bus master. It generates two-phase shift clocks and a per-byte select strobe, and assembles bytes from `SPI_SI` LSB-first. Each byte is written into the RA1SHD 512x8 SRAM at descending addresses, starting at `ADDR_BGN`, for `DATA_LEN+1` bytes. It sits beside the readout interface and `SRAM_IO_CTRL`; the top level muxes SRAM `A`/`CEN`/`D_WE` among them.

## Interface
- `MEMORY_DATA_WIDTH`, 8, SRAM word width and bits per serial frame
- `MEMORY_ADDR_WIDTH`, 9, SRAM address width
- `RESERVED_DATA_LEN`, 8, width of the `DATA_LEN` count
- `CLK`  in  1  system clock; all state updates on its rising edge
- `RST_N`  in  1  reset, asynchronous, active-low
- `BGN`  in  1  start/enable; must stay high for the whole transfer
- `ADDR_BGN`  in  9  first (highest) SRAM address written; sampled on leaving IDLE
- `DATA_LEN`  in  8  byte count minus one; sampled on leaving IDLE
- `SPI_SI`  in  1  serial data from the external shifter
- `SCLK1`  out  1  phase-1 shift clock
- `SCLK2`  out  1  phase-2 shift clock
- `SEL`  out  1  one-cycle strobe telling the external device to present its next byte
- `CEN`  out  1  SRAM chip enable, active-low
- `D_WE`  out  1  SRAM write enable, 1 = write
- `A`  out  9  SRAM address
- `PO`  out  8  SRAM write data
- `spi_is_done`  out  1  transfer complete

## Operation
- All outputs are registered.
- Reset values: `SCLK1=0`, `SCLK2=0`, `SEL=0`, `CEN=1`, `D_WE=0`, `A=0`, `PO=0`, `spi_is_done=0`, state IDLE.
- Internal registers:
  - 9-bit address `addr_r`
  - 8-bit remaining count `cnt_r`
  - 8-bit shift register `sh_r`
  - 3-bit bit counter
  - 2-bit phase counter
- State IDLE:
  - Outputs at reset values.
  - If `BGN=1`: load `addr_r<=ADDR_BGN` and `cnt_r<=DATA_LEN`, then go to SEL.
- State SEL:
  - `SEL=1` for exactly one cycle; clear the bit and phase counters.
  - Go to SHIFT.
- State SHIFT: 8 bit slots of 4 cycles each.
  - Phase 0: `SCLK1=1`.
  - Phase 1: both clocks 0.
  - Phase 2: `SCLK2=1`; `SPI_SI` is sampled at the rising edge that ends phase 2, `sh_r <= {SPI_SI, sh_r[7:1]}`, so the first bit received lands in bit 0.
  - Phase 3: both clocks 0.
  - After slot 7 phase 3, go to WRITE.
- State WRITE:
  - One cycle with `CEN=0`, `D_WE=1`, `A=addr_r`, `PO=sh_r`.
  - Go to LOOP.
- State LOOP:
  - `CEN=1`, `D_WE=0`.
  - If `cnt_r==0`, go to DONE.
  - Otherwise `cnt_r<=cnt_r-1`, `addr_r<=addr_r-1` (mod 512), and go to SEL.
- State DONE:
  - `spi_is_done=1`, SRAM idle.
  - Hold until `BGN=0`, then go to IDLE (done clears on that edge).
- Boundary conditions:
  - Address wrap: `ADDR_BGN < DATA_LEN` wraps 0 -> 511; no error.
  - `DATA_LEN=0`: exactly one byte is written.
  - `DATA_LEN=255`: 256 bytes are written.
  - `BGN` low in SEL, SHIFT, WRITE or LOOP: return to IDLE on the next edge with all outputs at reset values. The partial byte is discarded; bytes already written remain.
  - `RST_N` low at any time: immediate return to reset values regardless of state.
  - `ADDR_BGN`/`DATA_LEN` changes after start are ignored.

## Timing
- Take cycle 0 as the edge where IDLE samples `BGN=1`.
- Byte k (k=0..DATA_LEN):
  - `SEL` high in cycle 1+35k.
  - SHIFT occupies cycles 2+35k .. 33+35k.
  - `SCLK1` is high in cycles 2+35k+4b; `SCLK2` is high in cycles 4+35k+4b, for b = 0..7.
  - WRITE (SRAM write) in cycle 34+35k.
  - LOOP in cycle 35+35k.
- Throughput: 35 cycles per byte.
- `spi_is_done` rises in cycle 35·(DATA_LEN+1)+1.
- `SCLK1` and `SCLK2` are never high together.
- The external device must hold `SPI_SI` stable through each `SCLK2` high cycle.

## Test plan
- Single byte, ADDR_BGN=9'h030, DATA_LEN=0, serial 0xA5 LSB-first -> one write at `A=0x030`, `PO=0xA5` in cycle 34; `spi_is_done=1` in cycle 36; read back 0xA5.
- 14-byte transfer, ADDR_BGN=45, DATA_LEN=13, bytes = the 14-byte program image (0x..., HALT last) -> SRAM[45..32] hold the bytes in descending order; 14 `SEL` pulses; done at cycle 491; zero mismatches against the baseline memory.
- Wrap case, ADDR_BGN=1, DATA_LEN=3, data 0x11,0x22,0x33,0x44 -> writes to addresses 1, 0, 511, 510 in that order.
- Abort: drop `BGN` during byte 1 SHIFT -> IDLE next edge with `CEN=1`; only byte 0 is written; `spi_is_done` stays 0.
- Reset mid-WRITE: assert `RST_N=0` in cycle 34 -> all outputs at reset values asynchronously. After release with `BGN=1`, a fresh transfer restarts from `ADDR_BGN`.
- Clock check over any transfer: `SCLK1&SCLK2` is never 1, and each bit slot is exactly 4 cycles; `DATA_LEN=0` is compared against `DATA_LEN=255` for count correctness (1 vs 256 writes).

Source files
------------

// File: rtl/pseudo_spi_rx_intf_if.sv
// Bus bundle between the serial-to-SRAM loader and its surroundings: start/config
// inputs, the serial line, the shift clocks/select strobe and the SRAM write port.
interface pseudo_spi_rx_intf_if #(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 9,
    parameter int RESERVED_DATA_LEN = 8
);
    logic                         BGN;
    logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN;
    logic [RESERVED_DATA_LEN-1:0] DATA_LEN;
    logic                         SPI_SI;
    logic                         SCLK1;
    logic                         SCLK2;
    logic                         SEL;
    logic                         CEN;
    logic                         D_WE;
    logic [MEMORY_ADDR_WIDTH-1:0] A;
    logic [MEMORY_DATA_WIDTH-1:0] PO;
    logic                         spi_is_done;

    // The loader is the bus master: it owns the clocks, the strobe and the SRAM port.
    modport master (
        input  BGN, ADDR_BGN, DATA_LEN, SPI_SI,
        output SCLK1, SCLK2, SEL, CEN, D_WE, A, PO, spi_is_done
    );

    modport slave (
        output BGN, ADDR_BGN, DATA_LEN, SPI_SI,
        input  SCLK1, SCLK2, SEL, CEN, D_WE, A, PO, spi_is_done
    );
endinterface

// File: rtl/pseudo_spi_rx_intf.sv
// Serial-to-SRAM loader: shifts bytes in LSB-first with two-phase clocks and writes
// them to descending SRAM addresses. Every output is registered one cycle behind the FSM.
module pseudo_spi_rx_intf #(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 9,
    parameter int RESERVED_DATA_LEN = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    pseudo_spi_rx_intf_if.master bus
);
    localparam int BIT_W = $clog2(MEMORY_DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_SHIFT, S_WRITE, S_LOOP, S_DONE
    } state_t;

    typedef struct packed {
        logic                         sclk1;
        logic                         sclk2;
        logic                         sel;
        logic                         cen;
        logic                         d_we;
        logic [MEMORY_ADDR_WIDTH-1:0] a;
        logic [MEMORY_DATA_WIDTH-1:0] po;
        logic                         done;
    } out_t;

    localparam out_t OUT_RST = '{cen: 1'b1, default: '0};

    state_t                       state_q, state_d;
    logic [MEMORY_ADDR_WIDTH-1:0] addr_r, addr_d;
    logic [RESERVED_DATA_LEN-1:0] cnt_r, cnt_d;
    logic [MEMORY_DATA_WIDTH-1:0] sh_r;
    logic [BIT_W-1:0]             bit_q, bit_d;
    logic [1:0]                   phase_q, phase_d;
    out_t                         out_q, out_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            addr_r  <= '0;
            cnt_r   <= '0;
            sh_r    <= '0;
            bit_q   <= '0;
            phase_q <= '0;
            out_q   <= OUT_RST;
        end else begin
            state_q <= state_d;
            addr_r  <= addr_d;
            cnt_r   <= cnt_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            out_q   <= out_d;
            // Sample at the edge that closes the cycle in which SCLK2 is high.
            if (out_q.sclk2) sh_r <= {bus.SPI_SI, sh_r[MEMORY_DATA_WIDTH-1:1]};
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_r;
        cnt_d   = cnt_r;
        bit_d   = bit_q;
        phase_d = phase_q;
        out_d   = OUT_RST;

        if (!bus.BGN) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    addr_d  = bus.ADDR_BGN;
                    cnt_d   = bus.DATA_LEN;
                    state_d = S_SEL;
                end
                S_SEL: begin
                    out_d.sel = 1'b1;
                    bit_d     = '0;
                    phase_d   = '0;
                    state_d   = S_SHIFT;
                end
                S_SHIFT: begin
                    out_d.sclk1 = (phase_q == 2'd0);
                    out_d.sclk2 = (phase_q == 2'd2);
                    phase_d     = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        bit_d = bit_q + BIT_W'(1);
                        if (bit_q == BIT_W'(MEMORY_DATA_WIDTH - 1)) state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    out_d.cen  = 1'b0;
                    out_d.d_we = 1'b1;
                    out_d.a    = addr_r;
                    out_d.po   = sh_r;
                    state_d    = S_LOOP;
                end
                S_LOOP: begin
                    if (cnt_r == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_r - RESERVED_DATA_LEN'(1);
                        addr_d  = addr_r - MEMORY_ADDR_WIDTH'(1);
                        state_d = S_SEL;
                    end
                end
                S_DONE: out_d.done = 1'b1;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.SCLK1       = out_q.sclk1;
    assign bus.SCLK2       = out_q.sclk2;
    assign bus.SEL         = out_q.sel;
    assign bus.CEN         = out_q.cen;
    assign bus.D_WE        = out_q.d_we;
    assign bus.A           = out_q.a;
    assign bus.PO          = out_q.po;
    assign bus.spi_is_done = out_q.done;
endmodule

// File: tb/tb_pseudo_spi_rx_intf.sv
// Bench for the serial-to-SRAM loader: a cycle-timing model derived from the byte/slot
// schedule, an SRAM model that logs writes, and directed transfers incl. abort and reset.
module tb_pseudo_spi_rx_intf;
    logic CLK;
    logic RST_N;

    pseudo_spi_rx_intf_if #(.MEMORY_DATA_WIDTH(8), .MEMORY_ADDR_WIDTH(9), .RESERVED_DATA_LEN(8)) bus ();

    pseudo_spi_rx_intf #(.MEMORY_DATA_WIDTH(8), .MEMORY_ADDR_WIDTH(9), .RESERVED_DATA_LEN(8)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    logic [7:0] tx      [256];
    logic [7:0] sram    [512];
    logic [7:0] exp_mem [512];
    logic [8:0] wr_a [$];
    logic [7:0] wr_d [$];

    logic        exp_valid = 1'b0;
    logic [22:0] exp_outs;
    int          cur_cyc;
    int          done_cyc;
    int          sel_cnt;
    int          overlap = 0;

    logic [7:0] img [14] = '{8'h3C, 8'h01, 8'h7E, 8'h42, 8'h81, 8'h18, 8'hE7,
                             8'h24, 8'h5A, 8'hC3, 8'h99, 8'h66, 8'h0F, 8'hFF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [22:0] pack(input logic s1, input logic s2, input logic sel,
                                         input logic cen, input logic we, input logic [8:0] a,
                                         input logic [7:0] po, input logic done);
        return {s1, s2, sel, cen, we, a, po, done};
    endfunction

    function automatic logic [22:0] rst_outs();
        return pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 8'h00, 1'b0);
    endfunction

    function automatic logic [22:0] dut_outs();
        return pack(bus.SCLK1, bus.SCLK2, bus.SEL, bus.CEN, bus.D_WE, bus.A, bus.PO, bus.spi_is_done);
    endfunction

    // Expected outputs in cycle c: byte k owns cycles 1+35k .. 35+35k.
    function automatic logic [22:0] model_at(input int c, input int addr, input int n,
                                             input int cut, input int kind);
        int k, r, rel;
        if ((kind == 2 && c >= cut) || (kind != 2 && c > cut)) return rst_outs();
        if (c < 1) return rst_outs();
        if (c >= 35 * n + 1) return pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 8'h00, 1'b1);
        k = (c - 1) / 35;
        r = (c - 1) % 35;
        if (r == 0) return pack(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 8'h00, 1'b0);
        if (r <= 32) begin
            rel = r - 1;
            return pack(rel % 4 == 0, rel % 4 == 2, 1'b0, 1'b1, 1'b0, 9'h000, 8'h00, 1'b0);
        end
        if (r == 33) return pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'((addr - k + 512) % 512), tx[k], 1'b0);
        return rst_outs();
    endfunction

    // External shifter: the right bit during each SCLK2-high cycle, noise elsewhere.
    function automatic logic si_at(input int c, input int n);
        int k, r;
        if (c >= 2) begin
            k = (c - 2) / 35;
            r = (c - 2) % 35;
            if (k < n && r < 32 && r % 4 == 2) return tx[k][r / 4];
        end
        return 1'($urandom);
    endfunction

    always @(posedge CLK) begin
        if (RST_N && bus.CEN === 1'b0 && bus.D_WE === 1'b1) begin
            sram[bus.A] <= bus.PO;
            wr_a.push_back(bus.A);
            wr_d.push_back(bus.PO);
        end
    end

    always @(negedge CLK) begin
        if (exp_valid) begin
            check($sformatf("outs@%0d", cur_cyc), 32'(dut_outs()), 32'(exp_outs));
            if (bus.SCLK1 && bus.SCLK2) overlap++;
            if (bus.SEL) sel_cnt++;
            if (bus.spi_is_done && done_cyc < 0) done_cyc = cur_cyc;
        end
    end

    // kind: 0 = full transfer, 1 = BGN dropped in cycle cut, 2 = RST_N asserted in cycle cut.
    task automatic run_transfer(input int addr, input int len, input int kind, input int cut_in);
        int n, cut, nw, mism;
        n   = len + 1;
        cut = (kind == 0) ? 35 * n + 2 : cut_in;
        wr_a.delete();
        wr_d.delete();
        done_cyc = -1;
        sel_cnt  = 0;
        @(posedge CLK); #2;
        bus.ADDR_BGN = 9'(addr);
        bus.DATA_LEN = 8'(len);
        bus.BGN      = 1'b1;
        for (int c = 0; c <= cut + 3; c++) begin
            @(posedge CLK); #2;
            cur_cyc = c;
            if (c == 1) begin
                bus.ADDR_BGN = ~9'(addr);
                bus.DATA_LEN = ~8'(len);
            end
            if (c == cut && kind == 2) begin
                RST_N = 1'b0;
                #1 check("async_rst", 32'(dut_outs()), 32'(rst_outs()));
            end
            if (c == cut && kind != 2) bus.BGN = 1'b0;
            exp_outs  = model_at(c, addr, n, cut, kind);
            exp_valid = 1'b1;
            bus.SPI_SI = si_at(c, n);
        end
        @(posedge CLK); #2;
        exp_valid  = 1'b0;
        bus.BGN    = 1'b0;
        bus.SPI_SI = 1'b0;
        RST_N      = 1'b1;
        nw = 0;
        for (int k = 0; k < n; k++)
            if ((kind == 2 && 34 + 35 * k < cut) || (kind != 2 && 34 + 35 * k <= cut)) nw++;
        check("wr_count", wr_a.size(), nw);
        for (int i = 0; i < nw && i < wr_a.size(); i++) begin
            check($sformatf("wr_addr[%0d]", i), 32'(wr_a[i]), (addr - i + 512) % 512);
            check($sformatf("wr_data[%0d]", i), 32'(wr_d[i]), 32'(tx[i]));
            exp_mem[(addr - i + 512) % 512] = tx[i];
        end
        mism = 0;
        for (int j = 0; j < 512; j++) if (sram[j] !== exp_mem[j]) mism++;
        check("mem_image", mism, 0);
    endtask

    initial begin
        for (int j = 0; j < 512; j++) begin
            sram[j]    = 8'h00;
            exp_mem[j] = 8'h00;
        end
        RST_N        = 1'b0;
        bus.BGN      = 1'b0;
        bus.ADDR_BGN = '0;
        bus.DATA_LEN = '0;
        bus.SPI_SI   = 1'b0;
        repeat (3) @(posedge CLK);
        #2 check("reset_outs", 32'(dut_outs()), 32'(rst_outs()));
        RST_N = 1'b1;
        repeat (2) @(posedge CLK);
        #2 check("idle_outs", 32'(dut_outs()), 32'(rst_outs()));

        // Single byte.
        tx[0] = 8'hA5;
        run_transfer(9'h030, 0, 0, 0);
        check("single_addr", 32'(wr_a[0]), 32'h030);
        check("single_data", 32'(wr_d[0]), 32'hA5);
        check("single_done_cyc", done_cyc, 36);
        check("single_readback", 32'(sram[9'h030]), 32'hA5);

        // 14-byte image.
        for (int i = 0; i < 14; i++) tx[i] = img[i];
        run_transfer(45, 13, 0, 0);
        check("img_done_cyc", done_cyc, 491);
        check("img_sel_pulses", sel_cnt, 14);
        check("img_first", 32'(sram[45]), 32'h3C);
        check("img_last", 32'(sram[32]), 32'hFF);

        // Address wrap.
        tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'h44;
        run_transfer(1, 3, 0, 0);
        check("wrap_a0", 32'(wr_a[0]), 1);
        check("wrap_a1", 32'(wr_a[1]), 0);
        check("wrap_a2", 32'(wr_a[2]), 511);
        check("wrap_a3", 32'(wr_a[3]), 510);
        check("wrap_d511", 32'(sram[511]), 32'h33);

        // Abort during byte 1 SHIFT.
        tx[0] = 8'hC6; tx[1] = 8'h5D; tx[2] = 8'hE1; tx[3] = 8'h7B;
        run_transfer(100, 3, 1, 50);
        check("abort_no_done", done_cyc, -1);
        check("abort_sel_pulses", sel_cnt, 2);
        check("abort_byte0", 32'(sram[100]), 32'hC6);

        // Reset during the first WRITE, then a fresh transfer.
        tx[0] = 8'h96; tx[1] = 8'h69; tx[2] = 8'hF0;
        run_transfer(200, 2, 2, 34);
        check("rst_no_write", wr_a.size(), 0);
        tx[0] = 8'h4B; tx[1] = 8'hB4; tx[2] = 8'h2D;
        run_transfer(200, 2, 0, 0);
        check("restart_addr0", 32'(wr_a[0]), 200);
        check("restart_done_cyc", done_cyc, 106);

        // Maximum length.
        for (int i = 0; i < 256; i++) tx[i] = 8'(i * 37 + 5);
        run_transfer(300, 255, 0, 0);
        check("max_writes", wr_a.size(), 256);
        check("max_done_cyc", done_cyc, 8961);

        check("sclk_overlap", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
